// File: rtl/stream_prefix_sum.sv
// Pipelined LANES x DW inclusive prefix sum with a running carry across beats and valid/ready back-pressure.
// Define PSUM_SAT_EN to make every adder saturate at 2^DW-1 instead of wrapping.
module stream_prefix_sum #(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int TAGW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_v,
  output logic                  in_ready,
  input  logic                  in_clr,
  input  logic [TAGW-1:0]       in_tag,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  out_v,
  input  logic                  out_ready,
  output logic [TAGW-1:0]       out_tag,
  output logic [LANES*DW-1:0]   out_data
);

  localparam int S = $clog2(LANES);

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef PSUM_SAT_EN
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
`else
    return a + b;
`endif
  endfunction

  // The whole pipeline, carry included, freezes only when a finished result is being held back.
  logic adv;
  assign adv      = !(out_v && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int OFF = 1 << k;

    logic            v_q;
    logic            clr_q;
    logic [TAGW-1:0] tag_q;
    vec_t            d_q;

    logic            src_v;
    logic            src_clr;
    logic [TAGW-1:0] src_tag;
    vec_t            src_d;
    vec_t            nxt_d;

    if (k == 0) begin : g_src
      assign src_v   = in_v && in_ready;
      assign src_clr = in_clr;
      assign src_tag = in_tag;
      assign src_d   = in_data;
    end else begin : g_src
      assign src_v   = g_stage[k-1].v_q;
      assign src_clr = g_stage[k-1].clr_q;
      assign src_tag = g_stage[k-1].tag_q;
      assign src_d   = g_stage[k-1].d_q;
    end

    always_comb begin
      nxt_d = src_d;
      for (int i = OFF; i < LANES; i++) begin
        nxt_d[i] = lane_add(src_d[i], src_d[i-OFF]);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        clr_q <= 1'b0;
        tag_q <= '0;
        d_q   <= '0;
      end else if (adv) begin
        v_q   <= src_v;
        clr_q <= src_clr;
        tag_q <= src_tag;
        d_q   <= nxt_d;
      end
    end
  end

  logic [DW-1:0] carry;
  logic [DW-1:0] base;
  vec_t          prefix;
  vec_t          sum_d;

  assign prefix = g_stage[S-1].d_q;

  always_comb begin
    base = g_stage[S-1].clr_q ? '0 : carry;
    for (int i = 0; i < LANES; i++) begin
      sum_d[i] = lane_add(base, prefix[i]);
    end
  end

  // Bubbles still flow through the output register but never touch the carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v    <= 1'b0;
      out_tag  <= '0;
      out_data <= '0;
      carry    <= '0;
    end else if (adv) begin
      out_v    <= g_stage[S-1].v_q;
      out_tag  <= g_stage[S-1].tag_q;
      out_data <= sum_d;
      if (g_stage[S-1].v_q) begin
        carry <= sum_d[LANES-1];
      end
    end
  end

endmodule

// File: tb/tb_stream_prefix_sum.sv
// Testbench for stream_prefix_sum: directed scenarios plus random traffic checked against a scoreboard model.
module tb_stream_prefix_sum;

  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int TAGW  = 3;
  localparam int VW    = LANES * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_v, in_ready, in_clr;
  logic [TAGW-1:0] in_tag;
  logic [VW-1:0]   in_data;
  logic            out_v, out_ready;
  logic [TAGW-1:0] out_tag;
  logic [VW-1:0]   out_data;

  logic            in_v4, in_ready4, in_clr4;
  logic [1:0]      in_tag4;
  logic [63:0]     in_data4;
  logic            out_v4, out_ready4;
  logic [1:0]      out_tag4;
  logic [63:0]     out_data4;

  always #5 clk = ~clk;

  stream_prefix_sum #(.LANES(LANES), .DW(DW), .TAGW(TAGW)) u_dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_ready(in_ready), .in_clr(in_clr), .in_tag(in_tag), .in_data(in_data),
    .out_v(out_v), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data)
  );

  stream_prefix_sum #(.LANES(4), .DW(16), .TAGW(2)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_v(in_v4), .in_ready(in_ready4), .in_clr(in_clr4), .in_tag(in_tag4), .in_data(in_data4),
    .out_v(out_v4), .out_ready(out_ready4), .out_tag(out_tag4), .out_data(out_data4)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [VW-1:0]   data;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] m_carry;

  // Reference: a plain left-to-right running sum starting from the carry.
  function automatic logic [VW-1:0] ref_prefix(input logic [VW-1:0] d, input logic clr,
                                               input logic [DW-1:0] carry);
    logic [63:0]   acc;
    logic [63:0]   maxv;
    logic [VW-1:0] r;
    maxv = (64'd1 << DW) - 64'd1;
    acc  = clr ? 64'd0 : {32'd0, carry};
    r    = '0;
    for (int i = 0; i < LANES; i++) begin
      acc = acc + {32'd0, d[DW*i +: DW]};
`ifdef PSUM_SAT_EN
      if (acc > maxv) acc = maxv;
`else
      acc = acc & maxv;
`endif
      r[DW*i +: DW] = acc[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp(input int first, input int step);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[DW*i +: DW] = DW'(first + step * i);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    beat_t b;
    if (reset) begin
      exp_q.delete();
      m_carry = '0;
    end else begin
      if (out_v && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_v && in_ready) begin
        b.tag  = in_tag;
        b.data = ref_prefix(in_data, in_clr, m_carry);
        exp_q.push_back(b);
        m_carry = b.data[DW*(LANES-1) +: DW];
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_v) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard: unexpected out_v=1 tag=%0d data=%h, expected no result", out_tag, out_data);
      end else if (out_data !== exp_q[0].data || out_tag !== exp_q[0].tag) begin
        miscompares++;
        $display("[TB] FAIL scoreboard: got tag=%0d data=%h, expected tag=%0d data=%h",
                 out_tag, out_data, exp_q[0].tag, exp_q[0].data);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [TAGW-1:0] tag, input logic [VW-1:0] data);
    bit done;
    done    = 1'b0;
    in_v    = 1'b1;
    in_clr  = clr;
    in_tag  = tag;
    in_data = data;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk);
      done = in_ready;
      @(negedge clk);
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  logic [VW-1:0]   res[4];
  logic [TAGW-1:0] res_tag[4];
  int              res_cyc[4];
  int              got;

  task automatic collect(input int n);
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      if (out_v) begin
        res[got]     = out_data;
        res_tag[got] = out_tag;
        res_cyc[got] = c;
        got++;
      end
      @(negedge clk);
    end
    checkOutput("collect_count", VW'(got), VW'(n));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    checkOutput("drain_empty", VW'(exp_q.size()), 0);
  endtask

  initial begin
    logic [VW-1:0] e1, e2;
    int lat, acc_n, n_out;

    reset = 1'b1; in_v = 0; in_clr = 0; in_tag = 0; in_data = '0; out_ready = 1'b1;
    in_v4 = 0; in_clr4 = 0; in_tag4 = 0; in_data4 = '0; out_ready4 = 1'b1;
    #1;
    checkOutput("reset_out_v", VW'(out_v), 0);
    checkOutput("reset_out_data", out_data, '0);
    checkOutput("reset_in_ready", VW'(in_ready), 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single beat: latency, tag and triangular sums.
    applyStimulus(1'b1, 3'd5, ramp(1, 1));
    in_v = 1'b0;
    lat = 1;
    while (!out_v && lat < 12) begin @(negedge clk); lat++; end
    checkOutput("latency", VW'(lat), 4);
    e1 = {32'd36, 32'd28, 32'd21, 32'd15, 32'd10, 32'd6, 32'd3, 32'd1};
    checkOutput("t1_data", out_data, e1);
    checkOutput("t1_tag", VW'(out_tag), 5);
    @(negedge clk);
    checkOutput("t1_out_v_drop", VW'(out_v), 0);

    // Back-to-back beats: carry chaining then clearing.
    applyStimulus(1'b1, 3'd1, ramp(1, 1));
    applyStimulus(1'b0, 3'd2, ramp(1, 0));
    applyStimulus(1'b1, 3'd3, ramp(1, 1));
    in_v = 1'b0;
    collect(3);
    checkOutput("t2_a", res[0], e1);
    checkOutput("t2_b", res[1], ramp(37, 1));
    checkOutput("t2_c", res[2], e1);
    checkOutput("t2_consecutive", VW'(res_cyc[2] - res_cyc[0]), 2);

    // Stall: fill the pipeline with out_ready low, then release.
    out_ready = 1'b0;
    acc_n = 0;
    for (int j = 0; j < 6; j++) begin
      in_v = 1'b1; in_clr = (j == 0); in_tag = TAGW'(j); in_data = ramp(j + 2, 3);
      @(posedge clk);
      if (in_ready) acc_n++;
      @(negedge clk);
    end
    in_v = 1'b0;
    checkOutput("t3_accepted", VW'(acc_n), 4);
    checkOutput("t3_in_ready_low", VW'(in_ready), 0);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_v) n_out++;
      @(negedge clk);
    end
    checkOutput("t3_results", VW'(n_out), 4);
    checkOutput("t3_empty", VW'(exp_q.size()), 0);

    // Overflow at the top of the lane range.
    e2 = '0;
    e2[31:0] = 32'hFFFF_FFF0;
    e2[63:32] = 32'h20;
    applyStimulus(1'b1, 3'd4, e2);
    applyStimulus(1'b0, 3'd6, ramp(1, 0));
    in_v = 1'b0;
    collect(2);
`ifdef PSUM_SAT_EN
    e1 = {VW{1'b1}};
    e1[31:0] = 32'hFFFF_FFF0;
    checkOutput("t4_overflow", res[0], e1);
    checkOutput("t4_after", res[1], {VW{1'b1}});
`else
    e1 = ramp(16, 0);
    e1[31:0] = 32'hFFFF_FFF0;
    checkOutput("t4_overflow", res[0], e1);
    checkOutput("t4_after", res[1], ramp(17, 1));
`endif

    // Asynchronous reset while stalled with beats in flight.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, ramp(5, 1));
    applyStimulus(1'b0, 3'd2, ramp(7, 2));
    applyStimulus(1'b0, 3'd3, ramp(9, 0));
    in_v = 1'b0;
    for (int c = 0; c < 10 && !out_v; c++) @(negedge clk);
    checkOutput("t5_out_v_before", VW'(out_v), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_out_v", VW'(out_v), 0);
    checkOutput("t5_out_data", out_data, '0);
    checkOutput("t5_out_tag", VW'(out_tag), 0);
    checkOutput("t5_in_ready", VW'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'd7, ramp(1, 0));
    in_v = 1'b0;
    collect(1);
    checkOutput("t5_after_reset", res[0], ramp(1, 1));
    checkOutput("t5_tag", VW'(res_tag[0]), 7);

    // Narrow instance: four 16-bit lanes.
    in_v4 = 1'b1; in_clr4 = 1'b1; in_tag4 = 2'd2;
    in_data4 = {16'd3, 16'd2, 16'd1, 16'hFFFF};
    @(posedge clk);
    @(negedge clk);
    in_v4 = 1'b0;
    lat = 1;
    while (!out_v4 && lat < 12) begin @(negedge clk); lat++; end
    checkOutput("t6_latency", VW'(lat), 3);
`ifdef PSUM_SAT_EN
    checkOutput("t6_data", VW'(out_data4), VW'(64'hFFFF_FFFF_FFFF_FFFF));
`else
    checkOutput("t6_data", VW'(out_data4), VW'({16'h0005, 16'h0002, 16'h0000, 16'hFFFF}));
`endif
    checkOutput("t6_tag", VW'(out_tag4), 2);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      in_v   = ($urandom % 4) != 0;
      in_clr = ($urandom % 6) == 0;
      in_tag = TAGW'($urandom);
      for (int i = 0; i < LANES; i++)
        in_data[DW*i +: DW] = (($urandom % 4) == 0) ? $urandom : ($urandom % 1000);
      out_ready = ($urandom % 3) != 0;
      @(negedge clk);
    end
    in_v = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
